mips_cpu_bus_arbiter: RTL and testbench
=======================================

Name: mips_cpu_bus_arbiter

Overview:
- Shares the single Avalon memory-mapped bus port of the multi-cycle CPU between two requesters: the instruction-fetch port and the load/store data port.
- Latches the granted request, drives it onto the bus until waitrequest drops, and routes memreaddata and completion back to the winner.
- Round-robin arbitration prevents starvation. A watchdog aborts transfers that stall too long.

Parameters:
- TIMEOUT_CYCLES, 1024, number of consecutive cycles waitrequest may stay high in a grant state before the transfer is aborted. Must be at least 2.
- TW, 11, width of the watchdog counter. Must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- if_read  in  1  fetch read request
- if_address  in  32  fetch word address
- if_readdata  out  32  fetch return data
- if_waitrequest  out  1  fetch stall; low for exactly the completion cycle
- d_read  in  1  data read request
- d_write  in  1  data write request
- d_address  in  32  data address
- d_writedata  in  32  store data
- d_byteenable  in  4  store/load byte lanes
- d_readdata  out  32  load return data
- d_waitrequest  out  1  data stall; low for exactly the completion cycle
- mem_address  out  32  bus address
- memread  out  1  bus read strobe
- memwrite  out  1  bus write strobe
- memwritedata  out  32  bus write data
- byteenable  out  4  bus byte lanes
- waitrequest  in  1  bus stall
- memreaddata  in  32  bus read data
- bus_error  out  1  one-cycle pulse on a watchdog abort
- grant_d  out  1  high while the data port owns the bus (debug)

Behaviour:
- Reset is asynchronous and active-high. It forces:
  - state to IDLE and last_grant to DATA, so fetch wins the first tie;
  - watchdog count to 0;
  - all bus strobes, mem_address, memwritedata, byteenable, bus_error and grant_d to 0;
  - if_waitrequest and d_waitrequest to 1.
- Reset mid-transfer drops the strobes immediately. The in-flight access is lost and the requesters must re-issue it.
- States: IDLE, GNT_I, GNT_D.
- IDLE transitions:
  - Only fetch requesting (if_read): latch it, go to GNT_I.
  - Only data requesting (d_read|d_write): latch it, go to GNT_D.
  - Both requesting: grant the port that is not last_grant.
  - No request: stay in IDLE.
- Grant states:
  - Bus outputs are registered from the latched request and are valid from the first cycle in GNT_x.
  - A requester's later changes to its inputs are ignored until completion.
- Completion: in GNT_x with waitrequest=0.
  - The granted port's waitrequest=0 that same cycle.
  - Its readdata = memreaddata (combinational pass-through).
  - last_grant updates to x and the state returns to IDLE next cycle. Strobes are 0 in IDLE.
- Non-granted port: waitrequest=1 at all times.
- Readdata: if_readdata and d_readdata always carry memreaddata. They are valid only in the completion cycle.
- Minimum access time is 2 cycles: request seen in IDLE at cycle 0, bus strobe in cycle 1, completion in cycle 1 if waitrequest=0. At most one bus transfer runs at a time; no idle gap is required between back-to-back grants beyond the IDLE cycle.
- d_read and d_write both high: treated as a write (memwrite=1, memread=0). Never both strobes at once.
- d_byteenable is passed through for data accesses. Fetch always drives byteenable=4'b1111.
- Watchdog:
  - The counter clears on entry to a grant state and increments each cycle waitrequest=1.
  - When the count reaches TIMEOUT_CYCLES:
    - bus_error pulses for 1 cycle;
    - the granted port gets waitrequest=0 with readdata forced to 32'h0;
    - the strobes drop and the state returns to IDLE;
    - last_grant updates as for a normal completion.
- grant_d = (state==GNT_D).

Test Plan:
- Fetch only: if_read=1, if_address=32'hBFC00000, waitrequest=0, memreaddata=32'h24020005 -> memread=1, mem_address=BFC00000, byteenable=F in cycle 1; if_waitrequest=0 with if_readdata=24020005 in cycle 1; IDLE in cycle 2.
- Simultaneous after reset: if_read=1, d_write=1 (addr 32'h00001000, data DEADBEEF, be 4'b0011) -> fetch granted first; data write issued on the next grant with memwrite=1, byteenable=3; fetch re-asserted alongside is granted after the data access (alternation).
- Stall: waitrequest=1 for 5 cycles in GNT_D on a read -> bus outputs held stable; d_waitrequest=1 throughout; completion on cycle 6 returns memreaddata; bus_error stays 0.
- Watchdog with TIMEOUT_CYCLES=8 and waitrequest stuck at 1 -> bus_error pulses exactly once, 8 cycles after grant; d_waitrequest=0 with d_readdata=0; strobes 0 next cycle.
- Reset asserted mid-GNT_I (async, between clock edges) -> memread falls before the next edge; both waitrequests=1; after release, the first tie grants fetch.
- Request change mid-transfer: d_address switched from 0x100 to 0x200 while stalled -> mem_address remains 0x100 until completion.

Source files
------------

// File: rtl/mips_cpu_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM bus port between instruction fetch
// and load/store, with a stall watchdog that aborts hung transfers.
module mips_cpu_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TW             = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_read,
  input  logic [31:0] if_address,
  output logic [31:0] if_readdata,
  output logic        if_waitrequest,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_readdata,
  output logic        d_waitrequest,
  output logic [31:0] mem_address,
  output logic        memread,
  output logic        memwrite,
  output logic [31:0] memwritedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] memreaddata,
  output logic        bus_error,
  output logic        grant_d
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t        r_state;
  logic          r_last_d;
  logic [TW-1:0] r_cnt;
  logic          r_memread;
  logic          r_memwrite;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic          r_grant_d;

  logic w_if_req;
  logic w_d_req;
  logic w_pick_d;
  logic w_busy;
  logic w_timeout;
  logic w_done;

  assign w_if_req  = if_read;
  assign w_d_req   = d_read | d_write;
  // On a tie the port that did not win last time gets the bus.
  assign w_pick_d  = w_d_req & (~w_if_req | ~r_last_d);
  assign w_busy    = (r_state != IDLE);
  assign w_timeout = w_busy & waitrequest & (r_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_done    = w_busy & (~waitrequest | w_timeout);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last_d   <= 1'b1;
      r_cnt      <= '0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_grant_d  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_if_req | w_d_req) begin
            r_cnt <= '0;
            if (w_pick_d) begin
              r_state    <= GNT_D;
              r_grant_d  <= 1'b1;
              r_addr     <= d_address;
              r_wdata    <= d_writedata;
              r_be       <= d_byteenable;
              r_memwrite <= d_write;
              r_memread  <= ~d_write;
            end else begin
              r_state    <= GNT_I;
              r_grant_d  <= 1'b0;
              r_addr     <= if_address;
              r_wdata    <= '0;
              r_be       <= 4'hF;
              r_memwrite <= 1'b0;
              r_memread  <= 1'b1;
            end
          end
        end
        GNT_I, GNT_D: begin
          if (w_done) begin
            r_state    <= IDLE;
            r_last_d   <= (r_state == GNT_D);
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_grant_d  <= 1'b0;
          end else if (waitrequest) begin
            r_cnt <= r_cnt + TW'(1);
          end
        end
        default: begin
          r_state    <= IDLE;
          r_memread  <= 1'b0;
          r_memwrite <= 1'b0;
          r_grant_d  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_address    = r_addr;
  assign memread        = r_memread;
  assign memwrite       = r_memwrite;
  assign memwritedata   = r_wdata;
  assign byteenable     = r_be;
  assign grant_d        = r_grant_d;
  assign bus_error      = w_timeout;

  // An aborted transfer returns zero instead of whatever the stalled bus shows.
  assign if_readdata    = w_timeout ? 32'h0 : memreaddata;
  assign d_readdata     = w_timeout ? 32'h0 : memreaddata;
  assign if_waitrequest = ~((r_state == GNT_I) & w_done);
  assign d_waitrequest  = ~((r_state == GNT_D) & w_done);

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Directed testbench for mips_cpu_bus_arbiter with a short watchdog timeout.
module tb_mips_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_read;
  logic [31:0] if_address;
  logic [31:0] if_readdata;
  logic        if_waitrequest;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic [31:0] d_readdata;
  logic        d_waitrequest;
  logic [31:0] mem_address;
  logic        memread;
  logic        memwrite;
  logic [31:0] memwritedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] memreaddata;
  logic        bus_error;
  logic        grant_d;

  int checks = 0;
  int errors = 0;

  mips_cpu_bus_arbiter #(.TIMEOUT_CYCLES(8), .TW(4)) dut (
    .clk(clk), .reset(reset),
    .if_read(if_read), .if_address(if_address), .if_readdata(if_readdata),
    .if_waitrequest(if_waitrequest),
    .d_read(d_read), .d_write(d_write), .d_address(d_address),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
    .mem_address(mem_address), .memread(memread), .memwrite(memwrite),
    .memwritedata(memwritedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .memreaddata(memreaddata),
    .bus_error(bus_error), .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_read = 0; if_address = 0; d_read = 0; d_write = 0; d_address = 0;
    d_writedata = 0; d_byteenable = 0; waitrequest = 0; memreaddata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (memread !== 1'b0) begin errors++; $display("FAIL reset_memread got %b exp 0", memread); end
    checks++; if (memwrite !== 1'b0) begin errors++; $display("FAIL reset_memwrite got %b exp 0", memwrite); end
    checks++; if (mem_address !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", mem_address); end
    checks++; if (memwritedata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", memwritedata); end
    checks++; if (byteenable !== 4'h0) begin errors++; $display("FAIL reset_be got %h exp 0", byteenable); end
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL reset_bus_error got %b exp 0", bus_error); end
    checks++; if (grant_d !== 1'b0) begin errors++; $display("FAIL reset_grant_d got %b exp 0", grant_d); end
    checks++; if (if_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_if_wait got %b exp 1", if_waitrequest); end
    checks++; if (d_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_d_wait got %b exp 1", d_waitrequest); end
  endtask

  task automatic test_fetch();
    do_reset();
    if_read = 1; if_address = 32'hBFC00000; waitrequest = 0; memreaddata = 32'h24020005;
    tick();
    checks++; if (memread !== 1'b1) begin errors++; $display("FAIL fetch_memread got %b exp 1", memread); end
    checks++; if (memwrite !== 1'b0) begin errors++; $display("FAIL fetch_memwrite got %b exp 0", memwrite); end
    checks++; if (mem_address !== 32'hBFC00000) begin errors++; $display("FAIL fetch_addr got %h exp BFC00000", mem_address); end
    checks++; if (byteenable !== 4'hF) begin errors++; $display("FAIL fetch_be got %h exp F", byteenable); end
    checks++; if (if_waitrequest !== 1'b0) begin errors++; $display("FAIL fetch_if_wait got %b exp 0", if_waitrequest); end
    checks++; if (if_readdata !== 32'h24020005) begin errors++; $display("FAIL fetch_rdata got %h exp 24020005", if_readdata); end
    checks++; if (d_waitrequest !== 1'b1) begin errors++; $display("FAIL fetch_d_wait got %b exp 1", d_waitrequest); end
    if_read = 0;
    tick();
    checks++; if (memread !== 1'b0) begin errors++; $display("FAIL fetch_idle_memread got %b exp 0", memread); end
    checks++; if (if_waitrequest !== 1'b1) begin errors++; $display("FAIL fetch_idle_if_wait got %b exp 1", if_waitrequest); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    if_read = 1; if_address = 32'h00400000;
    d_write = 1; d_address = 32'h00001000; d_writedata = 32'hDEADBEEF; d_byteenable = 4'b0011;
    waitrequest = 0; memreaddata = 32'h11112222;
    tick();
    checks++; if (memread !== 1'b1 || grant_d !== 1'b0) begin errors++; $display("FAIL tie_first_fetch got rd=%b gd=%b exp rd=1 gd=0", memread, grant_d); end
    checks++; if (mem_address !== 32'h00400000) begin errors++; $display("FAIL tie_fetch_addr got %h exp 00400000", mem_address); end
    checks++; if (d_waitrequest !== 1'b1) begin errors++; $display("FAIL tie_d_wait_ng got %b exp 1", d_waitrequest); end
    tick();
    checks++; if (memread !== 1'b0 || memwrite !== 1'b0) begin errors++; $display("FAIL tie_idle_strobes got rd=%b wr=%b exp 0 0", memread, memwrite); end
    tick();
    checks++; if (memwrite !== 1'b1 || memread !== 1'b0) begin errors++; $display("FAIL tie_data_write got wr=%b rd=%b exp wr=1 rd=0", memwrite, memread); end
    checks++; if (mem_address !== 32'h00001000) begin errors++; $display("FAIL tie_data_addr got %h exp 00001000", mem_address); end
    checks++; if (memwritedata !== 32'hDEADBEEF) begin errors++; $display("FAIL tie_data_wdata got %h exp DEADBEEF", memwritedata); end
    checks++; if (byteenable !== 4'h3) begin errors++; $display("FAIL tie_data_be got %h exp 3", byteenable); end
    checks++; if (grant_d !== 1'b1) begin errors++; $display("FAIL tie_grant_d got %b exp 1", grant_d); end
    checks++; if (d_waitrequest !== 1'b0 || if_waitrequest !== 1'b1) begin errors++; $display("FAIL tie_data_done got dw=%b iw=%b exp dw=0 iw=1", d_waitrequest, if_waitrequest); end
    d_write = 0;
    tick();
    tick();
    checks++; if (memread !== 1'b1 || grant_d !== 1'b0) begin errors++; $display("FAIL tie_alternate_fetch got rd=%b gd=%b exp rd=1 gd=0", memread, grant_d); end
    checks++; if (if_waitrequest !== 1'b0) begin errors++; $display("FAIL tie_alternate_if_wait got %b exp 0", if_waitrequest); end
    if_read = 0;
    tick();
  endtask

  task automatic test_read_write_both();
    idle_inputs();
    d_read = 1; d_write = 1; d_address = 32'h00002000; d_writedata = 32'h0BADF00D; d_byteenable = 4'hC;
    tick();
    checks++; if (memwrite !== 1'b1 || memread !== 1'b0) begin errors++; $display("FAIL rw_both got wr=%b rd=%b exp wr=1 rd=0", memwrite, memread); end
    checks++; if (byteenable !== 4'hC) begin errors++; $display("FAIL rw_both_be got %h exp C", byteenable); end
    d_read = 0; d_write = 0;
    tick();
  endtask

  task automatic test_stall();
    idle_inputs();
    d_read = 1; d_address = 32'h00000100; d_byteenable = 4'hF; waitrequest = 1; memreaddata = 32'h55555555;
    tick();
    d_address = 32'h00000200;
    d_read = 0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (memread !== 1'b1 || mem_address !== 32'h00000100) begin errors++; $display("FAIL stall_hold[%0d] got rd=%b addr=%h exp rd=1 addr=00000100", k, memread, mem_address); end
      checks++; if (d_waitrequest !== 1'b1 || bus_error !== 1'b0) begin errors++; $display("FAIL stall_wait[%0d] got dw=%b be=%b exp dw=1 be=0", k, d_waitrequest, bus_error); end
      tick();
    end
    waitrequest = 0; memreaddata = 32'hCAFEF00D;
    #1;
    checks++; if (d_waitrequest !== 1'b0) begin errors++; $display("FAIL stall_done_wait got %b exp 0", d_waitrequest); end
    checks++; if (d_readdata !== 32'hCAFEF00D) begin errors++; $display("FAIL stall_done_rdata got %h exp CAFEF00D", d_readdata); end
    checks++; if (mem_address !== 32'h00000100 || bus_error !== 1'b0) begin errors++; $display("FAIL stall_done_addr got %h err=%b exp 00000100 err=0", mem_address, bus_error); end
    tick();
    checks++; if (memread !== 1'b0 || d_waitrequest !== 1'b1) begin errors++; $display("FAIL stall_idle got rd=%b dw=%b exp rd=0 dw=1", memread, d_waitrequest); end
  endtask

  task automatic test_watchdog();
    int pulses = 0;
    idle_inputs();
    d_read = 1; d_address = 32'h00000300; d_byteenable = 4'hF; waitrequest = 1; memreaddata = 32'h12345678;
    tick();
    for (int k = 1; k < 8; k++) begin
      if (bus_error === 1'b1) pulses++;
      checks++; if (bus_error !== 1'b0 || d_waitrequest !== 1'b1) begin errors++; $display("FAIL wd_early[%0d] got err=%b dw=%b exp err=0 dw=1", k, bus_error, d_waitrequest); end
      tick();
    end
    if (bus_error === 1'b1) pulses++;
    checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL wd_pulse got %b exp 1", bus_error); end
    checks++; if (d_waitrequest !== 1'b0) begin errors++; $display("FAIL wd_d_wait got %b exp 0", d_waitrequest); end
    checks++; if (d_readdata !== 32'h0) begin errors++; $display("FAIL wd_rdata got %h exp 00000000", d_readdata); end
    d_read = 0;
    tick();
    if (bus_error === 1'b1) pulses++;
    checks++; if (memread !== 1'b0 || memwrite !== 1'b0 || grant_d !== 1'b0) begin errors++; $display("FAIL wd_strobes got rd=%b wr=%b gd=%b exp 0 0 0", memread, memwrite, grant_d); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL wd_pulse_count got %0d exp 1", pulses); end
    waitrequest = 0;
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    if_read = 1; if_address = 32'h00400010; waitrequest = 1;
    tick();
    checks++; if (memread !== 1'b1) begin errors++; $display("FAIL mid_pre_memread got %b exp 1", memread); end
    #1;
    reset = 1;
    #1;
    checks++; if (memread !== 1'b0) begin errors++; $display("FAIL mid_async_memread got %b exp 0", memread); end
    checks++; if (if_waitrequest !== 1'b1 || d_waitrequest !== 1'b1) begin errors++; $display("FAIL mid_waits got iw=%b dw=%b exp 1 1", if_waitrequest, d_waitrequest); end
    reset = 0;
    d_read = 1; d_address = 32'h00000400;
    tick();
    checks++; if (memread !== 1'b1 || grant_d !== 1'b0 || mem_address !== 32'h00400010) begin errors++; $display("FAIL mid_tie_fetch got rd=%b gd=%b addr=%h exp 1 0 00400010", memread, grant_d, mem_address); end
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_fetch();
    test_back_to_back();
    test_read_write_both();
    test_stall();
    test_watchdog();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
